// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared state types and change-code helpers for the vend dispenser
package vend_pkg;

    typedef enum logic [1:0] {V_IDLE, V_MOTOR, V_WAIT, V_FAULT} vend_state_t;
    typedef enum logic [1:0] {C_IDLE, C_ON, C_OFF} coin_state_t;

    localparam logic [1:0] CHG_NONE = 2'b00;
    localparam logic [1:0] CHG_5    = 2'b01;
    localparam logic [1:0] CHG_10   = 2'b10;
    localparam logic [1:0] CHG_15   = 2'b11;

    function automatic logic [1:0] coin_count(input logic [1:0] chg);
        case (chg)
            CHG_NONE: return 2'd0;
            CHG_5:    return 2'd1;
            CHG_10:   return 2'd2;
            CHG_15:   return 2'd3;
            default:  return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// rtl/cycle_timer.sv - loadable down-counter with zero flag
module cycle_timer #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/vend_dispenser.sv
// rtl/vend_dispenser.sv - product motor / drop check and coin-hopper payout with request queues
module vend_dispenser
    import vend_pkg::*;
#(
    parameter int MOTOR_CYCLES = 8,
    parameter int DROP_TIMEOUT = 32,
    parameter int HOP_ON       = 4,
    parameter int HOP_OFF      = 4,
    parameter int VEND_Q_DEPTH = 3,
    parameter int COIN_W       = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vend_in,
    input  logic [1:0] change_in,
    input  logic       drop_sense,
    output logic       motor_en,
    output logic       hopper_pulse,
    output logic       vend_done,
    output logic       busy,
    output logic       fault,
    output logic       ovf
);

    localparam int TW  = $clog2(MOTOR_CYCLES + DROP_TIMEOUT + HOP_ON + HOP_OFF);
    localparam int QW  = $clog2(VEND_Q_DEPTH + 1);
    localparam int CW1 = COIN_W + 1;

    vend_state_t       vstate;
    coin_state_t       cstate;
    logic [QW-1:0]     pend_v;
    logic [COIN_W-1:0] pend_c;
    logic [COIN_W:0]   c_sum;
    logic              sync1, sync2, sync3;
    logic              drop_rise, drop_seen, done_evt;
    logic              vend_take, coin_take;
    logic              vt_load, vt_zero, ct_load, ct_zero;
    logic [TW-1:0]     vt_val, ct_val;

    assign drop_rise = sync2 & ~sync3;
    assign vend_take = (vstate == V_IDLE) && (pend_v != '0);
    assign coin_take = (pend_c != '0) && ((cstate == C_IDLE) || (cstate == C_OFF && ct_zero));

    // One timer per engine; the load value depends on which phase is being entered.
    assign vt_load = vend_take || (vstate == V_MOTOR && vt_zero);
    assign vt_val  = (vstate == V_IDLE) ? TW'(MOTOR_CYCLES - 1) : TW'(DROP_TIMEOUT - 1);
    assign ct_load = coin_take || (cstate == C_ON && ct_zero);
    assign ct_val  = (cstate == C_ON) ? TW'(HOP_OFF - 1) : TW'(HOP_ON - 1);
    assign c_sum   = {1'b0, pend_c} + CW1'(coin_count(change_in)) - CW1'(coin_take);

    cycle_timer #(.W(TW)) u_vend_timer (
        .clk(clk), .rst(rst), .load(vt_load), .load_val(vt_val), .zero(vt_zero)
    );

    cycle_timer #(.W(TW)) u_coin_timer (
        .clk(clk), .rst(rst), .load(ct_load), .load_val(ct_val), .zero(ct_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= drop_sense;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_v <= '0;
            pend_c <= '0;
            ovf    <= 1'b0;
        end else begin
            if (vend_in && !vend_take) begin
                if (pend_v == QW'(VEND_Q_DEPTH)) ovf <= 1'b1;
                else                             pend_v <= pend_v + 1'b1;
            end else if (!vend_in && vend_take) begin
                pend_v <= pend_v - 1'b1;
            end
            if (c_sum[COIN_W]) begin
                pend_c <= '1;
                ovf    <= 1'b1;
            end else begin
                pend_c <= c_sum[COIN_W-1:0];
            end
        end
    end

    // Outputs are decoded from the previous cycle's state, so every output lags the FSM by one edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vstate    <= V_IDLE;
            motor_en  <= 1'b0;
            done_evt  <= 1'b0;
            vend_done <= 1'b0;
            fault     <= 1'b0;
            drop_seen <= 1'b0;
        end else begin
            motor_en  <= (vstate == V_MOTOR);
            vend_done <= done_evt;
            fault     <= fault | (vstate == V_FAULT);
            done_evt  <= 1'b0;
            if (drop_rise) drop_seen <= 1'b1;
            case (vstate)
                V_IDLE: if (vend_take) begin
                    vstate    <= V_MOTOR;
                    drop_seen <= 1'b0;
                end
                V_MOTOR: if (vt_zero) begin
                    if (drop_seen || drop_rise) begin
                        vstate   <= V_IDLE;
                        done_evt <= 1'b1;
                    end else begin
                        vstate <= V_WAIT;
                    end
                end
                V_WAIT: if (drop_seen || drop_rise) begin
                    vstate   <= V_IDLE;
                    done_evt <= 1'b1;
                end else if (vt_zero) begin
                    vstate <= V_FAULT;
                end
                default: vstate <= V_FAULT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cstate       <= C_IDLE;
            hopper_pulse <= 1'b0;
        end else begin
            hopper_pulse <= (cstate == C_ON);
            case (cstate)
                C_IDLE:  if (coin_take) cstate <= C_ON;
                C_ON:    if (ct_zero) cstate <= C_OFF;
                C_OFF:   if (ct_zero) cstate <= coin_take ? C_ON : C_IDLE;
                default: cstate <= C_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= 1'b0;
        end else begin
            busy <= (pend_v != '0) || (pend_c != '0) || (vstate != V_IDLE) || (cstate != C_IDLE);
        end
    end

endmodule

// File: tb/tb_vend_dispenser.sv
// tb/tb_vend_dispenser.sv - directed bench with a timeline model of the vend dispenser
module tb_vend_dispenser;

    localparam int M = 8, T = 32, ON = 4, OFF = 4, DEPTH = 3, CMAX = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic       vend_in, drop_sense;
    logic [1:0] change_in;
    logic       motor_en, hopper_pulse, vend_done, busy, fault, ovf;

    int checks = 0, errors = 0, cyc = 0;

    vend_dispenser dut (
        .clk(clk), .rst(rst), .vend_in(vend_in), .change_in(change_in), .drop_sense(drop_sense),
        .motor_en(motor_en), .hopper_pulse(hopper_pulse), .vend_done(vend_done),
        .busy(busy), .fault(fault), .ovf(ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Model: each engine is a run start time; phases follow from elapsed cycles.
    int  me = 0, v_start = -1, c_start = -1, pv = 0, pc = 0;
    bit  v_drop, v_faulted, m_ovf, h1, h2, h3;
    bit  n_motor, n_hop, n_done, n_busy, n_fault;
    bit  exp_motor, exp_hop, exp_done, exp_busy, exp_fault, exp_ovf;
    bit  rise, can_v, take_v, can_c, take_c, fin;
    int  el, s;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_start = -1; c_start = -1; pv = 0; pc = 0;
            v_drop = 0; v_faulted = 0; m_ovf = 0; h1 = 0; h2 = 0; h3 = 0;
            {n_motor, n_hop, n_done, n_busy, n_fault} = '0;
            {exp_motor, exp_hop, exp_done, exp_busy, exp_fault, exp_ovf} = '0;
        end else begin
            {exp_motor, exp_hop, exp_done, exp_busy, exp_fault} = {n_motor, n_hop, n_done, n_busy, n_fault};
            me++;
            rise = h2 && !h3;
            h3 = h2; h2 = h1; h1 = drop_sense;
            can_v = (v_start < 0) && !v_faulted;
            fin = 0;
            if (v_start >= 0) begin
                if (rise) v_drop = 1;
                el = me - v_start;
                if (el >= M && v_drop) begin
                    fin = 1; v_start = -1;
                end else if (el == M + T) begin
                    v_faulted = 1; v_start = -1;
                end
            end
            take_v = can_v && pv > 0;
            if (vend_in && !take_v) begin
                if (pv == DEPTH) m_ovf = 1;
                else pv++;
            end else if (!vend_in && take_v) begin
                pv--;
            end
            if (take_v) begin v_start = me; v_drop = 0; end

            can_c = (c_start < 0) || (me - c_start == ON + OFF);
            if (c_start >= 0 && me - c_start == ON + OFF) c_start = -1;
            take_c = can_c && pc > 0;
            s = pc + int'(change_in) - (take_c ? 1 : 0);
            if (s > CMAX) begin s = CMAX; m_ovf = 1; end
            pc = s;
            if (take_c) c_start = me;

            n_motor = (v_start >= 0) && (me - v_start < M);
            n_hop   = (c_start >= 0) && (me - c_start < ON);
            n_done  = fin;
            n_fault = v_faulted;
            n_busy  = (pv != 0) || (pc != 0) || (v_start >= 0) || v_faulted || (c_start >= 0);
            exp_ovf = m_ovf;
        end
    end

    always @(negedge clk) begin
        chk("motor_en", motor_en, exp_motor);
        chk("hopper_pulse", hopper_pulse, exp_hop);
        chk("vend_done", vend_done, exp_done);
        chk("busy", busy, exp_busy);
        chk("fault", fault, exp_fault);
        chk("ovf", ovf, exp_ovf);
    end

    // Observation statistics, sampled 1 time unit after each rising edge.
    bit auto_drop, pm, ph, pf, overlap;
    int motor_hi, first_motor, hop_hi, hop_rises, done_cnt, last_done, fault_rise;
    int hop_at[4];
    int e0, dcyc, lat;

    task automatic clear_stats();
        motor_hi = 0; first_motor = -1; hop_hi = 0; hop_rises = 0;
        done_cnt = 0; last_done = -1; fault_rise = -1; overlap = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (auto_drop) drop_sense = motor_en;
        if (motor_en) motor_hi++;
        if (motor_en && !pm && first_motor < 0) first_motor = cyc;
        if (hopper_pulse && !ph) begin
            if (hop_rises < 4) hop_at[hop_rises] = cyc;
            hop_rises++;
        end
        if (hopper_pulse) hop_hi++;
        if (vend_done) begin done_cnt++; last_done = cyc; end
        if (fault && !pf && fault_rise < 0) fault_rise = cyc;
        if (motor_en && hopper_pulse) overlap = 1;
        pm = motor_en; ph = hopper_pulse; pf = fault;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
    endtask

    initial begin
        vend_in = 0; change_in = 2'b00; drop_sense = 0; auto_drop = 0;
        rst = 1'b1;
        #1 rst = 1'b0;
        clear_stats();
        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk("reset_motor", motor_en, 0);
        chk("reset_hopper", hopper_pulse, 0);
        chk("reset_busy", busy, 0);
        chk("reset_fault", fault, 0);
        chk("reset_ovf", ovf, 0);

        // 1: single vend, drop 3 cycles after the motor stops
        clear_stats();
        vend_in = 1; tick(); vend_in = 0; e0 = cyc;
        repeat (13) tick();
        drop_sense = 1; dcyc = cyc;
        repeat (6) tick();
        drop_sense = 0;
        repeat (10) tick();
        chk("t1_motor_latency", first_motor - e0, 2);
        chk("t1_motor_cycles", motor_hi, 8);
        chk("t1_done_count", done_cnt, 1);
        lat = last_done - dcyc;
        chk("t1_done_within_4", int'(lat >= 1 && lat <= 4), 1);
        chk("t1_busy_end", busy, 0);

        // 2: two coins
        clear_stats();
        change_in = 2'b10; tick(); change_in = 2'b00; e0 = cyc;
        repeat (30) tick();
        chk("t2_pulses", hop_rises, 2);
        chk("t2_high_cycles", hop_hi, 8);
        chk("t2_first_latency", hop_at[0] - e0, 2);
        chk("t2_pulse_spacing", hop_at[1] - hop_at[0], 8);
        chk("t2_busy_end", busy, 0);

        // 3: no drop -> fault; coins still paid; no further motor runs
        clear_stats();
        vend_in = 1; tick(); vend_in = 0;
        repeat (50) tick();
        chk("t3_fault", fault, 1);
        chk("t3_fault_delay", fault_rise - first_motor, 40);
        chk("t3_motor_cycles", motor_hi, 8);
        chk("t3_no_done", done_cnt, 0);
        clear_stats();
        change_in = 2'b01; tick(); change_in = 2'b00;
        repeat (20) tick();
        chk("t3_coin_in_fault", hop_rises, 1);
        clear_stats();
        vend_in = 1; tick(); vend_in = 0;
        repeat (15) tick();
        chk("t3_motor_stays_off", motor_hi, 0);
        do_reset();
        chk("t3_fault_cleared", fault, 0);

        // 4: five back-to-back requests, queue holds three
        clear_stats();
        auto_drop = 1;
        vend_in = 1; repeat (5) tick(); vend_in = 0;
        repeat (60) tick();
        auto_drop = 0; drop_sense = 0;
        chk("t4_done_count", done_cnt, 4);
        chk("t4_motor_cycles", motor_hi, 32);
        chk("t4_ovf", ovf, 1);
        chk("t4_fault", fault, 0);

        // 5: vend and three coins together
        do_reset();
        clear_stats();
        auto_drop = 1;
        vend_in = 1; change_in = 2'b11; tick(); vend_in = 0; change_in = 2'b00;
        repeat (40) tick();
        auto_drop = 0; drop_sense = 0;
        tick();
        chk("t5_done_count", done_cnt, 1);
        chk("t5_pulses", hop_rises, 3);
        chk("t5_overlap", overlap, 1);
        chk("t5_fault", fault, 0);
        chk("t5_ovf", ovf, 0);
        chk("t5_busy_end", busy, 0);

        // 6: reset in the middle of motor and hopper activity
        clear_stats();
        vend_in = 1; change_in = 2'b11; tick(); vend_in = 0; change_in = 2'b00;
        repeat (4) tick();
        chk("t6_motor_active", motor_en, 1);
        chk("t6_hopper_active", hopper_pulse, 1);
        #1 rst = 1'b0;
        #1;
        chk("t6_async_motor", motor_en, 0);
        chk("t6_async_hopper", hopper_pulse, 0);
        chk("t6_async_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        clear_stats();
        repeat (30) tick();
        chk("t6_no_motor", motor_hi, 0);
        chk("t6_no_hopper", hop_hi, 0);
        chk("t6_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
